stopwatch_display_core: RTL and testbench

- Centisecond stopwatch that sits directly downstream of the frequency divider.
- Consumes the divider's 100 Hz square wave (clk_100) as a count tick and its 2-bit scan select (clk_ctl) for the display.
- Counts SS.hh (00.00 to 59.99) under start/pause and lap/clear pushbuttons.
- Drives the 4-digit multiplexed 7-segment display directly.

---
 rtl/stopwatch_display_core.sv | 219 +++++++++++++++++++++
 tb/tb_stopwatch_display_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_display_core.sv
// stopwatch_display_core
//   Centisecond stopwatch (SS.hh) driven by the divider's 100 Hz square wave,
//   with start/pause and lap/clear pushbuttons and a directly driven 4-digit
//   multiplexed 7-segment display.
//
// Ports:
//   clk          system clock (shared with the divider)
//   rst_n        asynchronous active-low reset
//   clk_100      100 Hz square wave, synchronous to clk
//   clk_ctl      2-bit digit scan select from the divider
//   start_pb     start/pause request, one-clk pulse
//   lap_pb       lap/clear request, one-clk pulse
//   running      high while in RUN
//   lap_hold     high while the display is frozen on the lap value
//   wrap         one-cycle pulse when the count rolls over to 00.00
//   bcd_digits   live count {s_tens,s_ones,cs_tens,cs_ones}
//   ssd_ctl      one-hot digit enables, bit0 = rightmost digit
//   ssd_seg      segments {a,b,c,d,e,f,g,dp}
module stopwatch_display_core #(
  parameter int MAX_SEC_TENS   = 5,
  parameter bit SSD_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_100,
  input  logic [1:0]  clk_ctl,
  input  logic        start_pb,
  input  logic        lap_pb,
  output logic        running,
  output logic        lap_hold,
  output logic        wrap,
  output logic [15:0] bcd_digits,
  output logic [3:0]  ssd_ctl,
  output logic [7:0]  ssd_seg
);

  localparam logic [3:0] MAX_ST = 4'(MAX_SEC_TENS);

  // Idle level of the display buses after polarity is applied.
  localparam logic [3:0] CTL_OFF = SSD_ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [7:0] SEG_OFF = SSD_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] held_q, held_d;
  logic        hold_q, hold_d;
  logic        wrap_q, wrap_d;
  logic        clk100_dly_q;
  logic        armed_q;
  logic        clr;
  logic        tick;
  logic [3:0]  ssd_ctl_q, ssd_ctl_d;
  logic [7:0]  ssd_seg_q, ssd_seg_d;

  // Increment a 4-digit BCD count; bit 16 flags the rollover to 00.00.
  function automatic logic [16:0] bcd_inc(input logic [15:0] c);
    logic [3:0] st, so, ct, co;
    logic       wr;
    st = c[15:12];
    so = c[11:8];
    ct = c[7:4];
    co = c[3:0];
    wr = 1'b0;
    if (co != 4'd9) begin
      co = co + 4'd1;
    end else begin
      co = 4'd0;
      if (ct != 4'd9) begin
        ct = ct + 4'd1;
      end else begin
        ct = 4'd0;
        if (so != 4'd9) begin
          so = so + 4'd1;
        end else begin
          so = 4'd0;
          if (st != MAX_ST) begin
            st = st + 4'd1;
          end else begin
            st = 4'd0;
            wr = 1'b1;
          end
        end
      end
    end
    return {wr, st, so, ct, co};
  endfunction

  // Active-low segment pattern, dp off; anything that is not BCD is blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h03;
      4'd1:    return 8'h9F;
      4'd2:    return 8'h25;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h99;
      4'd5:    return 8'h49;
      4'd6:    return 8'h41;
      4'd7:    return 8'h1F;
      4'd8:    return 8'h01;
      4'd9:    return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  // armed_q holds off tick detection for the first cycle after reset release,
  // so a divider output that is already high is not mistaken for an edge.
  assign tick = clk_100 & ~clk100_dly_q & armed_q;

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ----
  // start_pb takes priority over lap_pb when both arrive together.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    held_d  = held_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pb) state_d = RUN;
      end
      RUN: begin
        if (start_pb) begin
          state_d = PAUSE;
        end else if (lap_pb) begin
          hold_d = ~hold_q;
          if (!hold_q) held_d = cnt_q;
        end
      end
      PAUSE: begin
        if (start_pb) begin
          state_d = RUN;
        end else if (lap_pb) begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            state_d = IDLE;
            clr     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    running  = (state_q == RUN);
    lap_hold = hold_q;
  end

  // Count datapath: a tick in the same cycle as RUN->PAUSE still counts,
  // because the increment is gated on the current state.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = 16'h0000;
    end else if ((state_q == RUN) && tick) begin
      {wrap_d, cnt_d} = bcd_inc(cnt_q);
    end
  end

  // Display scan: select digit from the frozen or live value, then decode.
  always_comb begin
    logic [15:0] disp;
    logic [3:0]  dig;
    logic [7:0]  raw;
    disp = hold_q ? held_q : cnt_q;
    case (clk_ctl)
      2'd0:    begin dig = disp[3:0];   ssd_ctl_d = 4'b1110; end
      2'd1:    begin dig = disp[7:4];   ssd_ctl_d = 4'b1101; end
      2'd2:    begin dig = disp[11:8];  ssd_ctl_d = 4'b1011; end
      default: begin dig = disp[15:12]; ssd_ctl_d = 4'b0111; end
    endcase
    raw = seg_decode(dig);
    if (clk_ctl == 2'd2) raw[0] = 1'b0;
    ssd_seg_d = SSD_ACTIVE_LOW ? raw : ~raw;
    if (!SSD_ACTIVE_LOW) ssd_ctl_d = ~ssd_ctl_d;
  end

  // ---- Register stage: count, lap, tick edge detect, display ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= 16'h0000;
      held_q       <= 16'h0000;
      hold_q       <= 1'b0;
      wrap_q       <= 1'b0;
      clk100_dly_q <= 1'b0;
      armed_q      <= 1'b0;
      ssd_ctl_q    <= CTL_OFF;
      ssd_seg_q    <= SEG_OFF;
    end else begin
      cnt_q        <= cnt_d;
      held_q       <= held_d;
      hold_q       <= hold_d;
      wrap_q       <= wrap_d;
      clk100_dly_q <= clk_100;
      armed_q      <= 1'b1;
      ssd_ctl_q    <= ssd_ctl_d;
      ssd_seg_q    <= ssd_seg_d;
    end
  end

  assign wrap       = wrap_q;
  assign bcd_digits = cnt_q;
  assign ssd_ctl    = ssd_ctl_q;
  assign ssd_seg    = ssd_seg_q;

endmodule

// File: tb/tb_stopwatch_display_core.sv
module tb_stopwatch_display_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_100 = 1'b0;
  logic [1:0]  clk_ctl = 2'd0;
  logic        start_pb = 1'b0;
  logic        lap_pb = 1'b0;
  logic        running, lap_hold, wrap;
  logic [15:0] bcd_digits;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;

  stopwatch_display_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_100    (clk_100),
    .clk_ctl    (clk_ctl),
    .start_pb   (start_pb),
    .lap_pb     (lap_pb),
    .running    (running),
    .lap_hold   (lap_hold),
    .wrap       (wrap),
    .bcd_digits (bcd_digits),
    .ssd_ctl    (ssd_ctl),
    .ssd_seg    (ssd_seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] seg;
  } scan_t;

  int total = 0;
  int bad = 0;

  // Reference model state: 0 = IDLE, 1 = RUN, 2 = PAUSE.
  int m_st = 0;
  int m_cs = 0;
  int m_held = 0;
  bit m_hold = 1'b0;

  logic [15:0] cnt_exp_q[$];
  logic [15:0] cnt_obs_q[$];
  scan_t       scan_exp_q[$];
  scan_t       scan_obs_q[$];

  logic [7:0] seg_tab [0:9] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic l);
    start_pb = s;
    lap_pb   = l;
    step();
    start_pb = 1'b0;
    lap_pb   = 1'b0;
    if (s) begin
      m_st = (m_st == 1) ? 2 : 1;
    end else if (l) begin
      if (m_st == 1) begin
        if (!m_hold) m_held = m_cs;
        m_hold = ~m_hold;
      end else if (m_st == 2) begin
        if (m_hold) m_hold = 1'b0;
        else begin
          m_st = 0;
          m_cs = 0;
        end
      end
    end
  endtask

  // One rising edge of clk_100; expected and observed counts are queued.
  task automatic tick();
    clk_100 = 1'b1;
    step();
    if (m_st == 1) m_cs = (m_cs + 1) % 6000;
    cnt_exp_q.push_back(to_bcd(m_cs));
    cnt_obs_q.push_back(bcd_digits);
    clk_100 = 1'b0;
    step();
  endtask

  // Walk clk_ctl through all four digits, queuing expected and observed buses.
  task automatic drive_scan(input logic [15:0] disp);
    for (int k = 0; k < 4; k++) begin
      scan_t e;
      logic [15:0] sh;
      logic [3:0] d;
      clk_ctl = 2'(k);
      sh = disp >> (4 * k);
      d = sh[3:0];
      e.ctl = ~(4'b0001 << k);
      e.seg = seg_tab[d] & ((k == 2) ? 8'hFE : 8'hFF);
      scan_exp_q.push_back(e);
      step();
      scan_obs_q.push_back({ssd_ctl, ssd_seg});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clk_100 = 1'b0;
    repeat (2) step();
    total++; if (bcd_digits !== 16'h0000) begin bad++; $display("FAIL reset_bcd got %h want 0000", bcd_digits); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got %b want 0", running); end
    total++; if (lap_hold !== 1'b0) begin bad++; $display("FAIL reset_lap_hold got %b want 0", lap_hold); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    total++; if (ssd_ctl !== 4'hF) begin bad++; $display("FAIL reset_ssd_ctl got %b want 1111", ssd_ctl); end
    total++; if (ssd_seg !== 8'hFF) begin bad++; $display("FAIL reset_ssd_seg got %h want ff", ssd_seg); end
    rst_n = 1'b1;
    step();
    pulse(1'b0, 1'b1);
    total++; if (lap_hold !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL idle_lap_ignored got hold=%b run=%b want 0 0", lap_hold, running); end
  endtask

  task automatic test_scan();
    drive_scan(16'h0000);
    while (scan_exp_q.size() > 0) begin
      scan_t e, o;
      e = scan_exp_q.pop_front();
      o = scan_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL scan_idle got ctl=%b seg=%h want ctl=%b seg=%h", o.ctl, o.seg, e.ctl, e.seg); end
    end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL scan_running got %b want 0", running); end
  endtask

  task automatic test_counting();
    pulse(1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got %b want 1", running); end
    repeat (150) tick();
    while (cnt_exp_q.size() > 0) begin
      logic [15:0] e, o;
      e = cnt_exp_q.pop_front();
      o = cnt_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL count got %h want %h", o, e); end
    end
    total++; if (bcd_digits !== 16'h0150) begin bad++; $display("FAIL count_150 got %h want 0150", bcd_digits); end
    clk_100 = 1'b1;
    repeat (10) step();
    m_cs = m_cs + 1;
    clk_100 = 1'b0;
    step();
    total++; if (bcd_digits !== 16'h0151) begin bad++; $display("FAIL held_high_once got %h want 0151", bcd_digits); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6000 && m_cs != 5999; i++) tick();
    while (cnt_exp_q.size() > 0) begin
      logic [15:0] e, o;
      e = cnt_exp_q.pop_front();
      o = cnt_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL count_to_max got %h want %h", o, e); end
    end
    total++; if (bcd_digits !== 16'h5999 || wrap !== 1'b0) begin bad++; $display("FAIL at_max got %h wrap=%b want 5999 wrap=0", bcd_digits, wrap); end
    clk_100 = 1'b1;
    step();
    m_cs = 0;
    total++; if (bcd_digits !== 16'h0000 || wrap !== 1'b1) begin bad++; $display("FAIL rollover got %h wrap=%b want 0000 wrap=1", bcd_digits, wrap); end
    clk_100 = 1'b0;
    step();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got %b want 0", wrap); end
    tick();
    void'(cnt_exp_q.pop_front());
    void'(cnt_obs_q.pop_front());
    total++; if (bcd_digits !== 16'h0001) begin bad++; $display("FAIL after_wrap got %h want 0001", bcd_digits); end
  endtask

  task automatic test_lap();
    for (int i = 0; i < 6000 && m_cs != 1234; i++) tick();
    cnt_exp_q.delete();
    cnt_obs_q.delete();
    total++; if (bcd_digits !== 16'h1234) begin bad++; $display("FAIL lap_start got %h want 1234", bcd_digits); end
    pulse(1'b0, 1'b1);
    total++; if (lap_hold !== 1'b1) begin bad++; $display("FAIL lap_on got %b want 1", lap_hold); end
    repeat (100) tick();
    while (cnt_exp_q.size() > 0) begin
      logic [15:0] e, o;
      e = cnt_exp_q.pop_front();
      o = cnt_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL count_in_lap got %h want %h", o, e); end
    end
    total++; if (bcd_digits !== 16'h1334) begin bad++; $display("FAIL lap_live got %h want 1334", bcd_digits); end
    drive_scan(16'h1234);
    pulse(1'b0, 1'b1);
    total++; if (lap_hold !== 1'b0) begin bad++; $display("FAIL lap_off got %b want 0", lap_hold); end
    drive_scan(16'h1334);
    while (scan_exp_q.size() > 0) begin
      scan_t e, o;
      e = scan_exp_q.pop_front();
      o = scan_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL scan_lap got ctl=%b seg=%h want ctl=%b seg=%h", o.ctl, o.seg, e.ctl, e.seg); end
    end
  endtask

  task automatic test_pause_clear();
    pulse(1'b1, 1'b0);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got %b want 0", running); end
    repeat (5) tick();
    while (cnt_exp_q.size() > 0) begin
      logic [15:0] e, o;
      e = cnt_exp_q.pop_front();
      o = cnt_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL count_paused got %h want %h", o, e); end
    end
    total++; if (bcd_digits !== 16'h1334) begin bad++; $display("FAIL paused_frozen got %h want 1334", bcd_digits); end
    pulse(1'b0, 1'b1);
    total++; if (bcd_digits !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL clear got %h run=%b want 0000 run=0", bcd_digits, running); end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    total++; if (lap_hold !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL run_lap got hold=%b run=%b want 1 1", lap_hold, running); end
    pulse(1'b1, 1'b1);
    total++; if (running !== 1'b0 || lap_hold !== 1'b1) begin bad++; $display("FAIL both_pb got run=%b hold=%b want 0 1", running, lap_hold); end
    pulse(1'b0, 1'b1);
    total++; if (lap_hold !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL pause_unlap got hold=%b run=%b want 0 0", lap_hold, running); end
  endtask

  task automatic test_async_reset();
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 6000 && m_cs != 789; i++) tick();
    cnt_exp_q.delete();
    cnt_obs_q.delete();
    pulse(1'b0, 1'b1);
    total++; if (bcd_digits !== 16'h0789 || lap_hold !== 1'b1) begin bad++; $display("FAIL pre_reset got %h hold=%b want 0789 hold=1", bcd_digits, lap_hold); end
    clk_ctl = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bcd_digits !== 16'h0000 || running !== 1'b0 || lap_hold !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL async_reset got bcd=%h run=%b hold=%b wrap=%b want 0000 0 0 0", bcd_digits, running, lap_hold, wrap); end
    total++; if (ssd_ctl !== 4'hF || ssd_seg !== 8'hFF) begin bad++; $display("FAIL async_reset_ssd got ctl=%b seg=%h want 1111 ff", ssd_ctl, ssd_seg); end
    m_st = 0; m_cs = 0; m_hold = 1'b0;
    clk_100 = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    total++; if (bcd_digits !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL after_release got %h run=%b want 0000 0", bcd_digits, running); end
    clk_100 = 1'b0;
    step();
    pulse(1'b1, 1'b0);
    total++; if (running !== 1'b1) begin bad++; $display("FAIL restart got %b want 1", running); end
    tick();
    while (cnt_exp_q.size() > 0) begin
      logic [15:0] e, o;
      e = cnt_exp_q.pop_front();
      o = cnt_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL count_restart got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_counting();
    test_wrap();
    test_lap();
    test_pause_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
